// File: rtl/sd_pic_sched.sv
// Purpose: schedules the single-block SD reads that copy one picture into SDRAM,
//          re-issuing a sector on error or watchdog expiry and flagging exhaustion.
// Latency: rd_start rises the cycle after wr_ready is seen; 3-cycle turnaround per sector after rd_done.
// Backpressure: no sector is issued while wr_ready is low; abort cancels the load on the next edge.
//
// Ports:
//   SD_clk, rst                    clock and asynchronous active-high reset
//   sdram_init_done, sd_init_done  readiness levels gating load_req
//   load_req, pic_sel              load request pulse and picture index
//   abort                          level; returns the scheduler to IDLE
//   wr_ready                       SDRAM write side can take one sector
//   rd_start, rd_sec               read launch pulse and sector address
//   rd_done, rd_err                read completion / failure pulses
//   load_busy, load_done, load_err, sec_cnt  load status
module sd_pic_sched #(
    parameter logic [31:0] SADDR      = 32'd16448,
    parameter logic [31:0] PIC_STRIDE = 32'd3072,
    parameter logic [11:0] SEC_LENGTH = 12'd3072,
    parameter logic [23:0] TIMEOUT    = 24'd4000000,
    parameter logic [1:0]  MAX_RETRY  = 2'd3
) (
    input  logic        SD_clk,
    input  logic        rst,
    input  logic        sdram_init_done,
    input  logic        sd_init_done,
    input  logic        load_req,
    input  logic [1:0]  pic_sel,
    input  logic        abort,
    input  logic        wr_ready,
    output logic        rd_start,
    output logic [31:0] rd_sec,
    input  logic        rd_done,
    input  logic        rd_err,
    output logic        load_busy,
    output logic        load_done,
    output logic        load_err,
    output logic [11:0] sec_cnt
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] WAIT_RDY  = 3'd1;
    localparam logic [2:0] ISSUE     = 3'd2;
    localparam logic [2:0] WAIT_DONE = 3'd3;
    localparam logic [2:0] NEXT      = 3'd4;
    localparam logic [2:0] DONE      = 3'd5;
    localparam logic [2:0] ERROR     = 3'd6;

    logic [2:0]  state;
    logic [2:0]  state_nxt;
    logic [31:0] base;
    logic [1:0]  retry;
    logic [23:0] wdog;
    logic        accept;
    logic        timed_out;
    logic [2:0]  fail_state;

    assign accept     = (state == IDLE) && load_req && sdram_init_done && sd_init_done && !abort;
    assign timed_out  = (wdog == TIMEOUT - 24'd1);
    assign fail_state = (retry < MAX_RETRY) ? ISSUE : ERROR;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (accept) state_nxt = WAIT_RDY;
            WAIT_RDY:  if (wr_ready) state_nxt = ISSUE;
            ISSUE:     state_nxt = WAIT_DONE;
            // rd_err beats rd_done, and rd_done beats a coincident timeout.
            WAIT_DONE: begin
                if (rd_err)
                    state_nxt = fail_state;
                else if (rd_done)
                    state_nxt = NEXT;
                else if (timed_out)
                    state_nxt = fail_state;
            end
            NEXT:      state_nxt = (sec_cnt + 12'd1 == SEC_LENGTH) ? DONE : WAIT_RDY;
            DONE:      state_nxt = IDLE;
            ERROR:     state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
        if (abort)
            state_nxt = IDLE;
    end

    // Status outputs are computed from the next state so they are registered
    // yet line up with the state they describe (e.g. rd_start high during ISSUE).
    always_ff @(posedge SD_clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rd_start  <= 1'b0;
            rd_sec    <= 32'd0;
            load_busy <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            sec_cnt   <= 12'd0;
            retry     <= 2'd0;
            wdog      <= 24'd0;
            base      <= SADDR;
        end else begin
            state     <= state_nxt;
            rd_start  <= (state_nxt == ISSUE);
            load_done <= (state_nxt == DONE);
            load_busy <= (state_nxt != IDLE) && (state_nxt != DONE) && (state_nxt != ERROR);

            if (accept) begin
                base     <= SADDR + {30'd0, pic_sel} * PIC_STRIDE;
                sec_cnt  <= 12'd0;
                retry    <= 2'd0;
                load_err <= 1'b0;
            end

            // A retry lands here with sec_cnt unchanged, so it reuses the address.
            if (state_nxt == ISSUE)
                rd_sec <= base + {20'd0, sec_cnt};

            if ((state == WAIT_DONE) && (state_nxt == ISSUE))
                retry <= retry + 2'd1;

            if ((state == NEXT) && !abort) begin
                sec_cnt <= sec_cnt + 12'd1;
                retry   <= 2'd0;
            end

            if (state_nxt == ERROR)
                load_err <= 1'b1;

            // The watchdog counts cycles since rd_start: zero in the ISSUE cycle,
            // so reaching TIMEOUT-1 re-issues exactly TIMEOUT cycles after rd_start.
            if (state_nxt == ISSUE)
                wdog <= 24'd0;
            else if ((state == ISSUE) || (state == WAIT_DONE))
                wdog <= wdog + 24'd1;
        end
    end

endmodule

// File: tb/tb_sd_pic_sched.sv
module tb_sd_pic_sched;

    localparam int          TO     = 100;
    localparam logic [31:0] SADDR  = 32'd16448;
    localparam logic [31:0] STRIDE = 32'd3072;
    localparam int          SECLEN = 3072;

    logic        SD_clk = 1'b0;
    logic        rst = 1'b1;
    logic        sdram_init_done = 1'b0;
    logic        sd_init_done = 1'b0;
    logic        load_req = 1'b0;
    logic [1:0]  pic_sel = 2'd0;
    logic        abort = 1'b0;
    logic        wr_ready = 1'b0;
    logic        rd_done;
    logic        rd_err;
    logic        rd_start;
    logic [31:0] rd_sec;
    logic        load_busy;
    logic        load_done;
    logic        load_err;
    logic [11:0] sec_cnt;

    sd_pic_sched #(.TIMEOUT(24'd100)) dut (
        .SD_clk(SD_clk), .rst(rst), .sdram_init_done(sdram_init_done),
        .sd_init_done(sd_init_done), .load_req(load_req), .pic_sel(pic_sel),
        .abort(abort), .wr_ready(wr_ready), .rd_start(rd_start), .rd_sec(rd_sec),
        .rd_done(rd_done), .rd_err(rd_err), .load_busy(load_busy),
        .load_done(load_done), .load_err(load_err), .sec_cnt(sec_cnt)
    );

    always #5 SD_clk = ~SD_clk;

    int cyc = 0;
    always @(posedge SD_clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Plan and model-of-load variables written by the main sequence.
    logic [31:0] exp_base = SADDR;
    logic [31:0] watch_addr = 32'd0;
    int load_id = 0;
    int lat_min = 1, lat_max = 1;
    int err_sec = -1, err_times = 0;
    bit collide = 0, silent = 0, to_mode = 0, stall = 0;

    // Model state written only by the responder: sectors completed in this load.
    int n_done = 0;

    // Monitor state.
    int n_starts = 0, n_ldone = 0, watch_hits = 0;
    int last_start = 0, last_id = -1;
    logic [31:0] first_sec = 32'd0;

    // SD read responder and the sector-progress model.
    initial begin
        int cd, attempt, seen;
        cd = 0; attempt = 0; seen = 0;
        rd_done = 1'b0;
        rd_err  = 1'b0;
        forever begin
            @(posedge SD_clk); #1;
            rd_done = 1'b0;
            rd_err  = 1'b0;
            if (seen != load_id) begin
                seen = load_id; n_done = 0; attempt = 0; cd = 0;
            end
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    if (n_done == err_sec && attempt <= err_times) begin
                        rd_err = 1'b1;
                        if (collide) rd_done = 1'b1;
                    end else begin
                        rd_done = 1'b1;
                        n_done++;
                        attempt = 0;
                    end
                end
            end
            if (rd_start && !silent) begin
                attempt++;
                cd = $urandom_range(lat_max, lat_min);
            end
        end
    end

    // Compare process: every issued read and every completion against the model.
    initial begin
        forever begin
            @(negedge SD_clk);
            if (!rst) begin
                if (rd_start) begin
                    check("rd_sec", rd_sec, exp_base + n_done);
                    check("sec_cnt_at_issue", 32'(sec_cnt), n_done);
                    check("busy_at_issue", 32'(load_busy), 1);
                    check("start_during_stall", 32'(stall), 0);
                    if (last_id != load_id)
                        first_sec = rd_sec;
                    else if (to_mode)
                        check("timeout_gap", cyc - last_start, TO);
                    if (rd_sec == watch_addr) watch_hits++;
                    last_id = load_id;
                    last_start = cyc;
                    n_starts++;
                end
                if (load_done) begin
                    check("sec_cnt_at_done", 32'(sec_cnt), SECLEN);
                    check("model_at_done", n_done, SECLEN);
                    check("busy_at_done", 32'(load_busy), 0);
                    n_ldone++;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge SD_clk);
        #1;
    endtask

    task automatic start_load(input logic [1:0] p);
        pic_sel  = p;
        exp_base = SADDR + 32'(p) * STRIDE;
        load_id++;
        load_req = 1'b1;
        tick(1);
        load_req = 1'b0;
        tick(1);
    endtask

    task automatic wait_ldone(input int budget, input string name);
        int n0, k;
        n0 = n_ldone; k = 0;
        while (n_ldone == n0 && k < budget) begin tick(1); k++; end
        check(name, n_ldone - n0, 1);
    endtask

    task automatic wait_err(input int budget, input string name);
        int k;
        k = 0;
        while (load_err !== 1'b1 && k < budget) begin tick(1); k++; end
        check(name, 32'(load_err), 1);
    endtask

    task automatic wait_ndone(input int target, input int budget, input string name);
        int k;
        k = 0;
        while (n_done < target && k < budget) begin tick(1); k++; end
        check(name, 32'(n_done >= target), 1);
    endtask

    initial begin
        int s0, d0, h0, k;

        // Reset values.
        tick(5);
        @(negedge SD_clk);
        check("rst_rd_start", 32'(rd_start), 0);
        check("rst_rd_sec", rd_sec, 0);
        check("rst_load_done", 32'(load_done), 0);
        check("rst_load_err", 32'(load_err), 0);
        check("rst_sec_cnt", 32'(sec_cnt), 0);
        check("rst_load_busy", 32'(load_busy), 0);
        @(posedge SD_clk); #1;
        rst = 1'b0;
        tick(2);

        // Gating: SDRAM not ready, the request is dropped.
        sd_init_done = 1'b1;
        wr_ready = 1'b1;
        s0 = n_starts;
        pic_sel = 2'd1;
        load_req = 1'b1;
        tick(1);
        load_req = 1'b0;
        tick(5);
        check("gated_busy", 32'(load_busy), 0);
        check("gated_starts", n_starts - s0, 0);

        // Nominal load of picture 1, with a stray load_req mid-load.
        sdram_init_done = 1'b1;
        lat_min = 10; lat_max = 10;
        s0 = n_starts;
        start_load(2'd1);
        tick(500);
        pic_sel = 2'd3;
        load_req = 1'b1;
        tick(1);
        load_req = 1'b0;
        wait_ldone(45000, "nominal_done");
        tick(2);
        check("nominal_starts", n_starts - s0, 3072);
        check("nominal_first", first_sec, 32'd19520);
        check("nominal_last", rd_sec, 32'd22591);
        check("nominal_sec_cnt", 32'(sec_cnt), 3072);
        check("nominal_err", 32'(load_err), 0);
        check("nominal_idle", 32'(load_busy), 0);

        // Retry: two errors on sector 5 of picture 0.
        lat_min = 1; lat_max = 3;
        err_sec = 5; err_times = 2;
        watch_addr = SADDR + 32'd5;
        h0 = watch_hits; s0 = n_starts;
        start_load(2'd0);
        wait_ldone(25000, "retry_done");
        tick(2);
        check("retry_sec5_issues", watch_hits - h0, 3);
        check("retry_starts", n_starts - s0, 3074);
        check("retry_err", 32'(load_err), 0);

        // Exhaustion: four failed attempts on sector 0.
        err_sec = 0; err_times = 4;
        s0 = n_starts; d0 = n_ldone;
        start_load(2'd2);
        wait_err(200, "exhaust_err");
        tick(3);
        check("exhaust_starts", n_starts - s0, 4);
        check("exhaust_no_done", n_ldone - d0, 0);
        check("exhaust_idle", 32'(load_busy), 0);
        check("exhaust_first", first_sec, 32'd22592);
        sd_init_done = 1'b0;
        load_req = 1'b1;
        tick(1);
        load_req = 1'b0;
        tick(3);
        check("err_sticky", 32'(load_err), 1);
        sd_init_done = 1'b1;

        // Timeout: no response at all; re-issue every TO cycles.
        err_sec = -1; err_times = 0;
        silent = 1; to_mode = 1;
        s0 = n_starts;
        start_load(2'd3);
        tick(2);
        check("err_cleared_on_load", 32'(load_err), 0);
        wait_err(600, "timeout_err");
        tick(3);
        check("timeout_starts", n_starts - s0, 4);
        check("timeout_first", first_sec, 32'd25664);
        check("timeout_idle", 32'(load_busy), 0);
        silent = 0; to_mode = 0;

        // Backpressure after sector 2, then abort during sector 7.
        lat_min = 1; lat_max = 3;
        d0 = n_ldone;
        start_load(2'($urandom_range(3, 0)));
        wait_ndone(3, 200, "bp_reach_sec3");
        wr_ready = 1'b0;
        stall = 1;
        s0 = n_starts;
        tick(50);
        check("stall_starts", n_starts - s0, 0);
        stall = 0;
        wr_ready = 1'b1;
        wait_ndone(7, 200, "bp_reach_sec7");
        s0 = n_starts; k = 0;
        while (n_starts == s0 && k < 50) begin tick(1); k++; end
        check("sec7_issued", n_starts - s0, 1);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        @(negedge SD_clk);
        check("abort_idle", 32'(load_busy), 0);
        check("abort_sec_cnt", 32'(sec_cnt), 7);
        check("abort_no_start", 32'(rd_start), 0);
        s0 = n_starts;
        tick(20);
        check("abort_no_done", n_ldone - d0, 0);
        check("abort_sec_cnt_held", 32'(sec_cnt), 7);
        check("abort_no_more_starts", n_starts - s0, 0);

        // Collision: rd_done with rd_err on sector 1 counts as an error.
        collide = 1; err_sec = 1; err_times = 1;
        watch_addr = SADDR + 32'd1;
        h0 = watch_hits;
        start_load(2'd0);
        wait_ndone(4, 200, "collide_progress");
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        tick(3);
        check("collide_sec1_issues", watch_hits - h0, 2);
        check("collide_err", 32'(load_err), 0);
        collide = 0; err_sec = -1; err_times = 0;

        // Reset mid-load abandons the load.
        d0 = n_ldone;
        start_load(2'd1);
        wait_ndone(3, 200, "rst_progress");
        rst = 1'b1;
        tick(1);
        @(negedge SD_clk);
        check("midrst_sec_cnt", 32'(sec_cnt), 0);
        check("midrst_busy", 32'(load_busy), 0);
        check("midrst_rd_sec", rd_sec, 0);
        tick(3);
        rst = 1'b0;
        tick(10);
        check("midrst_no_done", n_ldone - d0, 0);
        check("midrst_idle", 32'(load_busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sd_pic_sched.md
SD_PIC_SCHED -- requirements
Module: sd_pic_sched

Interface
REQ-001 Parameter SADDR, 32'd16448: first sector of picture 0.
REQ-002 Parameter PIC_STRIDE, 32'd3072: sector offset between consecutive pictures.
REQ-003 Parameter SEC_LENGTH, 12'd3072: sectors per picture (1024x768x2/512).
REQ-004 Parameter TIMEOUT, 24'd4000000: per-sector watchdog limit, in SD_clk cycles.
REQ-005 Parameter MAX_RETRY, 2'd3: re-issues allowed per sector after its first attempt.
REQ-006 SD_clk  in  1  sole clock; all logic on rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 sdram_init_done  in  1  SDRAM ready; level.
REQ-009 sd_init_done  in  1  SD card initialised; level.
REQ-010 load_req  in  1  one-cycle pulse requesting a picture load.
REQ-011 pic_sel  in  2  picture index, sampled with load_req.
REQ-012 abort  in  1  level; cancels any load in progress.
REQ-013 wr_ready  in  1  SDRAM write side can accept one sector (512 B).
REQ-014 rd_start  out  1  one-cycle pulse launching a single-block read.
REQ-015 rd_sec  out  32  sector address; valid from the rd_start cycle until the next rd_start.
REQ-016 rd_done  in  1  one-cycle pulse: block received correctly.
REQ-017 rd_err  in  1  one-cycle pulse: bad response or token.
REQ-018 load_busy  out  1  high in every state except IDLE, DONE and ERROR.
REQ-019 load_done  out  1  one-cycle pulse: whole picture read.
REQ-020 load_err  out  1  sticky error flag.
REQ-021 sec_cnt  out  12  sectors completed in the current load.

Function
REQ-022 The FSM SHALL use these states: IDLE, WAIT_RDY, ISSUE, WAIT_DONE, NEXT, DONE, ERROR.
REQ-023 IDLE: when load_req=1, sdram_init_done=1 and sd_init_done=1, the FSM SHALL latch base=SADDR+pic_sel*PIC_STRIDE (32-bit, wrap ignored), clear sec_cnt, retry and load_err, and go to WAIT_RDY; otherwise load_req SHALL be ignored.
REQ-024 WAIT_RDY: the FSM SHALL go to ISSUE on the first cycle wr_ready=1.
REQ-025 ISSUE: the FSM SHALL assert rd_start for exactly one cycle with rd_sec=base+sec_cnt, clear the watchdog, then go to WAIT_DONE.
REQ-026 WAIT_DONE: the watchdog SHALL increment each cycle; rd_done SHALL go to NEXT.
REQ-027 WAIT_DONE: rd_err, or watchdog reaching TIMEOUT-1, SHALL go to ISSUE with retry+1 if retry<MAX_RETRY, else to ERROR.
REQ-028 If rd_done and rd_err arrive in the same cycle, rd_err SHALL take priority; if rd_done coincides with the timeout, rd_done SHALL take priority.
REQ-029 NEXT: sec_cnt SHALL increment and retry SHALL clear; if the new sec_cnt equals SEC_LENGTH the FSM SHALL go to DONE, else to WAIT_RDY.
REQ-030 DONE: load_done SHALL be high for exactly this one cycle; the next state SHALL be IDLE.
REQ-031 ERROR: load_err SHALL be set; the FSM SHALL go to IDLE next cycle; load_err SHALL stay high until the next accepted load_req.
REQ-032 abort=1 in any state SHALL force IDLE on the next edge, with no load_done, no rd_start, and sec_cnt held at its value.
REQ-033 abort SHALL take priority over every other transition.
REQ-034 load_req arriving while load_busy=1 SHALL be ignored and not queued.
REQ-035 rd_done/rd_err outside WAIT_DONE SHALL be ignored.
REQ-036 A rd_start retry SHALL reuse the same rd_sec.

Reset
REQ-037 While rst=1 the block SHALL hold state=IDLE, rd_start=0, rd_sec=0, load_done=0, load_err=0, sec_cnt=0, retry=0, watchdog=0, base=SADDR.
REQ-038 Reset asserted mid-load SHALL abandon the load with no load_done pulse.
REQ-039 Outputs SHALL be registered; no output SHALL combinationally depend on inputs.

Verification
REQ-040 Nominal load: pic_sel=1, load_req, wr_ready=1, rd_done 10 cycles after each rd_start -> 3072 rd_starts with rd_sec 19520..22591, then one load_done, sec_cnt=3072.
REQ-041 Retry: rd_err on sector 5, twice -> rd_sec=SADDR+5 issued three times, load completes, load_err=0.
REQ-042 Exhaustion: rd_err on four consecutive attempts of sector 0 -> exactly four rd_starts, load_err=1, load_done never, returns to IDLE.
REQ-043 Timeout: no rd_done (TIMEOUT set to 100 in the bench) -> re-issue exactly 100 cycles after each rd_start; ERROR after 4 attempts.
REQ-044 Backpressure/abort: wr_ready=0 for 50 cycles after sector 2 -> no rd_start during that window; abort during sector 7 -> IDLE next edge, sec_cnt=7, no load_done.
REQ-045 Gating/collision: load_req while sdram_init_done=0 -> ignored; rd_done and rd_err in the same cycle -> treated as error (re-issue of the same sector).
